// File: rtl/csa_accumulator.sv
// ---------------------------------------------------------------------------
// csa_accumulator
//
// Purpose:
//   Frame-based accumulate/subtract stage built around the 16-bit carry
//   select adder CSA. A frame of len signed operands arrives over a
//   valid/ready handshake. Each operand is added to or subtracted from a
//   running sum. The frame result is then held on a valid/ready output port
//   until downstream takes it.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      frame start request (only looked at in IDLE)
//   len        number of operands in the frame, captured with start
//   in_valid   operand beat valid
//   in_ready   block can accept an operand beat (ACCUM only)
//   in_data    two's complement operand
//   in_sub     0: acc + in_data, 1: acc - in_data
//   out_valid  frame result valid (DONE only)
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum, wraps modulo 2^16
//   out_ovf    sticky signed overflow seen anywhere in the frame
//   out_carry  CSA carry-out of the last accepted beat (1 = no borrow on sub)
//   busy       high while in ACCUM or DONE
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// CSA
//
// Purpose:
//   16-bit carry select adder/subtractor made of four 4-bit blocks. Each
//   block forms its sum for both possible carry-ins. The real incoming carry
//   then picks one of the two. When mod is high, B is inverted and the
//   carry-in is forced to 1, which gives A - B.
//
// Ports:
//   A         first operand
//   B         second operand
//   mod       0: add, 1: subtract
//   Y         result, modulo 2^16
//   overflow  carry-out of bit 15 (unsigned carry / not-borrow)
// ---------------------------------------------------------------------------
module CSA (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        mod,
    output logic [15:0] Y,
    output logic        overflow
);

    logic [15:0] b_x;
    logic [4:0]  c;

    // Invert B for subtraction. The +1 of the two's complement is the
    // carry-in to the lowest block.
    assign b_x  = B ^ {16{mod}};
    assign c[0] = mod;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_blk
            logic [4:0] s0;
            logic [4:0] s1;

            // Both speculative sums are ready before the block carry-in
            // settles. Only a 2:1 mux sits on the carry chain.
            assign s0 = {1'b0, A[4*g+3:4*g]} + {1'b0, b_x[4*g+3:4*g]};
            assign s1 = {1'b0, A[4*g+3:4*g]} + {1'b0, b_x[4*g+3:4*g]} + 5'd1;

            assign Y[4*g+3:4*g] = c[g] ? s1[3:0] : s0[3:0];
            assign c[g+1]       = c[g] ? s1[4]   : s0[4];
        end
    endgenerate

    assign overflow = c[4];

endmodule

module csa_accumulator #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             out_carry,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [LEN_W-1:0] cnt;
    logic             ovf;
    logic             carry;

    logic [WIDTH-1:0] csa_y;
    logic             csa_co;
    logic [WIDTH-1:0] b_eff;
    logic             sovf;
    logic             accept;

    CSA u_csa (
        .A        (acc),
        .B        (in_data),
        .mod      (in_sub),
        .Y        (csa_y),
        .overflow (csa_co)
    );

    // Signed overflow of this beat. It looks at the effective second operand
    // that the adder actually sees. The operands must share a sign, and the
    // result must have the other sign. Subtracting the most negative value
    // is handled by itself: its true negation is not representable. The
    // result really overflows whenever acc is non-negative.
    always_comb begin
        b_eff = in_sub ? ~in_data : in_data;
        sovf  = (acc[WIDTH-1] == b_eff[WIDTH-1]) &&
                (csa_y[WIDTH-1] != acc[WIDTH-1]);
        if (in_sub && (in_data == MOST_NEG)) begin
            sovf = ~acc[WIDTH-1];
        end
    end

    assign accept = (state == S_ACCUM) && in_valid;

    // Frame control and datapath registers.
    // IDLE waits for start and clears the running state.
    // ACCUM folds one operand into acc per accepted beat and counts down.
    // DONE holds the result until the output handshake.
    // A start request outside IDLE is ignored. A zero-length frame goes
    // straight to DONE with an all-zero result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            carry <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        ovf   <= 1'b0;
                        carry <= 1'b0;
                        if (len != '0) begin
                            cnt   <= len;
                            state <= S_ACCUM;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        acc   <= csa_y;
                        carry <= csa_co;
                        ovf   <= ovf | sovf;
                        cnt   <= cnt - 1'b1;
                        if (cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode from state alone. This keeps any input from
    // reaching in_ready or out_valid combinationally.
    assign in_ready  = (state == S_ACCUM);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_ACCUM) || (state == S_DONE);

    assign out_sum   = acc;
    assign out_ovf   = ovf;
    assign out_carry = carry;

endmodule

// File: tb/tb_csa_accumulator.sv
// ---------------------------------------------------------------------------
// tb_csa_accumulator
//
// Self-checking bench for csa_accumulator. Frames are driven through the
// input handshake. Results are compared with a reference model that uses
// plain signed/unsigned integer arithmetic.
// ---------------------------------------------------------------------------
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_ovf;
    logic        out_carry;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-frame operand tables filled by each test
    logic [15:0] beat_data [0:255];
    logic        beat_sub  [0:255];

    // Reference model state
    logic [15:0] m_acc;
    bit          m_ovf;
    bit          m_carry;

    // Observations captured by the frame driver
    bit          obs_on_time;
    bit          obs_ready_ok;
    bit          obs_stable;
    bit          obs_idle_after;
    logic [15:0] obs_sum;
    logic        obs_ovf;
    logic        obs_carry;

    csa_accumulator #(.WIDTH(16), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_carry (out_carry),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Model one beat: true signed result, range test for overflow,
    // unsigned comparison for carry / not-borrow.
    task automatic model_beat(input logic [15:0] d, input bit sub);
        int a;
        int b;
        int s;
        a = $signed(m_acc);
        b = $signed(d);
        s = sub ? (a - b) : (a + b);
        if (s > 32767 || s < -32768) m_ovf = 1'b1;
        if (sub) m_carry = (m_acc >= d);
        else     m_carry = ((int'(m_acc) + int'(d)) > 65535);
        m_acc = s[15:0];
    endtask

    // Drive one frame and record what the DUT does.
    // gap_mode: 0 = no idle cycles, 1 = idle cycle before every beat,
    //           2 = random idle cycles.
    // hold: number of cycles out_ready is kept low once out_valid rises.
    // poke: pulse start while the frame is busy.
    task automatic drive_frame(input int n, input int gap_mode, input int hold, input bit poke);
        bit gap;
        @(negedge clk);
        start     = 1'b1;
        len       = n[7:0];
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_acc     = 16'h0000;
        m_ovf     = 1'b0;
        m_carry   = 1'b0;
        @(negedge clk);
        start        = 1'b0;
        obs_ready_ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            gap = (gap_mode == 1) ? 1'b1 : (gap_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                in_sub   = 1'($urandom_range(0, 1));
                start    = poke;
                len      = 8'd5;
                if (!in_ready || out_valid || !busy) obs_ready_ok = 1'b0;
                @(negedge clk);
                start = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = beat_data[i];
            in_sub   = beat_sub[i];
            if (!in_ready || out_valid || !busy) obs_ready_ok = 1'b0;
            @(negedge clk);
            model_beat(beat_data[i], beat_sub[i]);
        end
        in_valid    = 1'b0;
        obs_on_time = out_valid && !in_ready && busy;
        obs_sum     = out_sum;
        obs_ovf     = out_ovf;
        obs_carry   = out_carry;
        obs_stable  = 1'b1;
        for (int h = 0; h < hold; h++) begin
            start = poke;
            len   = 8'd5;
            @(negedge clk);
            if (!out_valid || out_sum !== obs_sum || out_ovf !== obs_ovf ||
                out_carry !== obs_carry) obs_stable = 1'b0;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        obs_idle_after = !out_valid && !busy && !in_ready;
        out_ready      = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_sub    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, busy, out_ovf, out_carry} !== 5'b0 || out_sum !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got valid=%b ready=%b busy=%b sum=%h ovf=%b carry=%b, expected all 0",
                     out_valid, in_ready, busy, out_sum, out_ovf, out_carry);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_outputs: got ready=%b valid=%b busy=%b, expected 0 0 0",
                     in_ready, out_valid, busy);
        end
    endtask

    task automatic test_add_basic();
        beat_data[0] = 16'h000C; beat_sub[0] = 1'b0;
        beat_data[1] = 16'h000A; beat_sub[1] = 1'b0;
        drive_frame(2, 0, 0, 1'b0);
        n_checks++;
        if (!obs_on_time) begin
            n_fail++;
            $display("[TB] FAIL add_latency: got out_valid=0 after last beat, expected 1");
        end
        n_checks++;
        if ({obs_sum, obs_ovf, obs_carry} !== {16'h0016, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL add_result: got sum=%h ovf=%b carry=%b, expected 0016 0 0",
                     obs_sum, obs_ovf, obs_carry);
        end
        n_checks++;
        if (!obs_idle_after) begin
            n_fail++;
            $display("[TB] FAIL add_return_idle: got not idle after handshake, expected idle");
        end
    endtask

    task automatic test_overflow_sticky();
        beat_data[0] = 16'h7FFF; beat_sub[0] = 1'b0;
        beat_data[1] = 16'h0001; beat_sub[1] = 1'b0;
        beat_data[2] = 16'h0001; beat_sub[2] = 1'b1;
        drive_frame(3, 0, 0, 1'b0);
        n_checks++;
        if (obs_sum !== 16'h7FFF || obs_ovf !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL ovf_sticky: got sum=%h ovf=%b, expected 7fff 1", obs_sum, obs_ovf);
        end
        n_checks++;
        if (obs_carry !== m_carry) begin
            n_fail++;
            $display("[TB] FAIL ovf_carry: got %b expected %b", obs_carry, m_carry);
        end
    endtask

    task automatic test_borrow();
        beat_data[0] = 16'hFFFE; beat_sub[0] = 1'b0;
        beat_data[1] = 16'hFFFF; beat_sub[1] = 1'b1;
        drive_frame(2, 0, 0, 1'b0);
        n_checks++;
        if ({obs_sum, obs_ovf, obs_carry} !== {16'hFFFF, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL borrow_result: got sum=%h ovf=%b carry=%b, expected ffff 0 0",
                     obs_sum, obs_ovf, obs_carry);
        end
    endtask

    task automatic test_stall_backpressure();
        for (int i = 0; i < 4; i++) begin
            beat_data[i] = 16'h0001;
            beat_sub[i]  = 1'b0;
        end
        drive_frame(4, 1, 3, 1'b1);
        n_checks++;
        if (!obs_ready_ok || !obs_on_time) begin
            n_fail++;
            $display("[TB] FAIL stall_handshake: got ready_ok=%b on_time=%b, expected 1 1",
                     obs_ready_ok, obs_on_time);
        end
        n_checks++;
        if (obs_sum !== 16'h0004 || obs_ovf !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL stall_sum: got sum=%h ovf=%b, expected 0004 0", obs_sum, obs_ovf);
        end
        n_checks++;
        if (!obs_stable) begin
            n_fail++;
            $display("[TB] FAIL stall_hold_stable: got result changed or valid dropped, expected held");
        end
        n_checks++;
        if (!obs_idle_after) begin
            n_fail++;
            $display("[TB] FAIL stall_return_idle: got not idle after handshake, expected idle");
        end
    endtask

    task automatic test_zero_len();
        drive_frame(0, 0, 1, 1'b0);
        n_checks++;
        if (!obs_on_time || !obs_stable) begin
            n_fail++;
            $display("[TB] FAIL zero_len_valid: got on_time=%b stable=%b, expected 1 1",
                     obs_on_time, obs_stable);
        end
        n_checks++;
        if (obs_sum !== 16'h0000 || obs_ovf !== 1'b0 || obs_carry !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL zero_len_result: got sum=%h ovf=%b carry=%b, expected 0000 0 0",
                     obs_sum, obs_ovf, obs_carry);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        start = 1'b1;
        len   = 8'd3;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'h5555;
        in_sub   = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({out_valid, in_ready, busy, out_ovf, out_carry} !== 5'b0 || out_sum !== 16'h0) begin
            n_fail++;
            $display("[TB] FAIL midframe_reset: got valid=%b ready=%b busy=%b sum=%h ovf=%b carry=%b, expected all 0",
                     out_valid, in_ready, busy, out_sum, out_ovf, out_carry);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midframe_no_result: got valid=%b busy=%b, expected 0 0", out_valid, busy);
        end
        beat_data[0] = 16'h1234;
        beat_sub[0]  = 1'b0;
        drive_frame(1, 0, 0, 1'b0);
        n_checks++;
        if (!obs_on_time || obs_sum !== 16'h1234) begin
            n_fail++;
            $display("[TB] FAIL after_reset_frame: got on_time=%b sum=%h, expected 1 1234",
                     obs_on_time, obs_sum);
        end
    endtask

    task automatic test_random_frames();
        int n;
        for (int f = 0; f < 25; f++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0:       beat_data[i] = 16'h8000;
                    1:       beat_data[i] = 16'($urandom_range(16'h7FF0, 16'h7FFF));
                    default: beat_data[i] = 16'($urandom);
                endcase
                beat_sub[i] = 1'($urandom_range(0, 1));
            end
            drive_frame(n, 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_sum !== m_acc || obs_ovf !== m_ovf || obs_carry !== m_carry) begin
                n_fail++;
                $display("[TB] FAIL random_result[%0d]: got sum=%h ovf=%b carry=%b, expected %h %b %b",
                         f, obs_sum, obs_ovf, obs_carry, m_acc, m_ovf, m_carry);
            end
            n_checks++;
            if (!obs_on_time || !obs_ready_ok || !obs_stable || !obs_idle_after) begin
                n_fail++;
                $display("[TB] FAIL random_handshake[%0d]: got on_time=%b ready_ok=%b stable=%b idle=%b, expected 1 1 1 1",
                         f, obs_on_time, obs_ready_ok, obs_stable, obs_idle_after);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_overflow_sticky();
        test_borrow();
        test_stall_backpressure();
        test_zero_len();
        test_reset_midframe();
        test_random_frames();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Sequential accumulate/subtract stage directly downstream of the 16-bit carry select adder `CSA`.
- Instantiates `CSA` once, with port order A, B, mod, Y, overflow. A = the accumulator register, B = the incoming operand, mod = the per-beat subtract select.
- Takes a frame of LEN signed operands over a valid/ready handshake, folds each into a running sum, and presents the frame result on a valid/ready output port.
- Used as the operand-reduction front end of the datapath.

Parameters:
- WIDTH, 16, datapath width. Fixed by `CSA`; no other value is supported.
- LEN_W, 8, width of the frame-length input and the internal beat counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start request; sampled only in IDLE.
- len  input  LEN_W  number of operands in the frame; sampled with start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- in_data  input  WIDTH  operand, two's complement.
- in_sub  input  1  0: acc + in_data; 1: acc - in_data. Drives `CSA` mod.
- out_valid  output  1  frame result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  accumulated sum.
- out_ovf  output  1  sticky signed overflow over the frame.
- out_carry  output  1  `CSA` carry-out of the last accepted beat.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- One clock; reset is synchronous and active-high.
- rst=1 at a clock edge:
  - state=IDLE.
  - acc, cnt, ovf and carry registers cleared to 0.
  - out_valid=0, in_ready=0, busy=0, out_sum=0, out_ovf=0, out_carry=0.
  - Reset mid-frame abandons the frame; no partial result is emitted.
- States:
  - IDLE:
    - in_ready=0, out_valid=0, busy=0.
    - start=1 with len!=0: acc<=0, ovf<=0, carry<=0, cnt<=len, go to ACCUM.
    - start=1 with len==0: acc<=0, ovf<=0, carry<=0, go straight to DONE.
  - ACCUM:
    - in_ready=1.
    - A beat is accepted on an edge where in_valid & in_ready.
    - On acceptance: acc<=Y, carry<=`CSA` carry-out, ovf<=ovf | sovf, cnt<=cnt-1.
    - If cnt==1 at acceptance, go to DONE.
    - in_valid low: state holds; no change to any register.
  - DONE:
    - out_valid=1, in_ready=0.
    - out_sum, out_ovf and out_carry driven from registers, stable until the handshake.
    - out_valid & out_ready at an edge: go to IDLE.
- Arithmetic:
  - Subtract is Y = acc + ~in_data + 1, computed inside `CSA` via mod.
  - carry=1 on subtract means no borrow.
  - Sum wraps modulo 2^16.
- Signed overflow, computed in this block:
  - sovf = (acc[15] == b_eff[15]) && (Y[15] != acc[15]).
  - b_eff = in_sub ? ~in_data : in_data.
  - For subtract of 0x8000, sovf uses the true result sign: sovf = (acc[15]==0).
- Latency:
  - The result is visible in the cycle after the last accepted beat.
  - Minimum frame duration is len+1 cycles, start to out_valid.
  - A result cycle with out_ready already high completes in that cycle; IDLE follows.
- start in ACCUM or DONE is ignored; no restart and no queueing.
- No combinational path from any input to in_ready or out_valid; both decode from state only.
- cnt never underflows: DONE is entered at cnt==1.

Test Plan:
- len=2, beats (0x000C, add), (0x000A, add), out_ready=1 → out_valid one cycle after 2nd beat; out_sum=0x0016, out_ovf=0, out_carry=0.
- len=3, beats (0x7FFF, add), (0x0001, add), (0x0001, sub) → after beat 2 acc=0x8000 with ovf set; final out_sum=0x7FFF, out_ovf=1 (sticky; beat 3 also overflows).
- len=2, beats (0xFFFE, add), (0xFFFF, sub) → out_sum=0xFFFF (-1), out_ovf=0, out_carry=0 (borrow).
- len=4, beats 0x0001 (add) with in_valid low on alternate cycles; out_ready low for 3 cycles; start pulsed while busy → out_sum=0x0004 held stable while out_valid=1; returns to IDLE only on out_ready; extra start has no effect.
- start with len=0 → out_valid=1 the next cycle, out_sum=0x0000, out_ovf=0, no beats accepted.
- len=3, rst asserted after the 1st beat → next edge all outputs 0 and state IDLE; new frame len=1, beat (0x1234, add) → out_sum=0x1234.
